// File: rtl/clint_timer_pkg.sv
// Shared CLINT definitions: register offsets, reset constants, address decode
// and byte-lane merge helpers.
package clint_timer_pkg;

   localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
   localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
   localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
   localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

   localparam logic [63:0] CLINT_MTIMECMP_RST = '1;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_MSIP,
      SEL_CMP_LO,
      SEL_CMP_HI,
      SEL_MTIME_LO,
      SEL_MTIME_HI
   } clint_sel_e;

   // Byte offset bits [1:0] are masked off, so every alias of a word decodes the same.
   function automatic clint_sel_e clint_decode(input logic [15:0] addr);
      clint_sel_e sel;
      case (addr & 16'hFFFC)
         CLINT_MSIP_OFF:        sel = SEL_MSIP;
         CLINT_MTIMECMP_LO_OFF: sel = SEL_CMP_LO;
         CLINT_MTIMECMP_HI_OFF: sel = SEL_CMP_HI;
         CLINT_MTIME_LO_OFF:    sel = SEL_MTIME_LO;
         CLINT_MTIME_HI_OFF:    sel = SEL_MTIME_HI;
         default:               sel = SEL_NONE;
      endcase
      return sel;
   endfunction

   function automatic logic [31:0] clint_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
      logic [31:0] merged;
      merged = old_val;
      for (int unsigned i = 0; i < 4; i++) begin
         if (wstrb[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/clint_timer_if.sv
// Request/acknowledge slave bus into the CLINT register window.
interface clint_timer_if;

   logic        clint_req;
   logic        clint_we;
   logic [15:0] clint_addr;
   logic [31:0] clint_wdata;
   logic [3:0]  clint_wstrb;
   logic [31:0] clint_rdata;
   logic        clint_ack;

   modport master (
      output clint_req, clint_we, clint_addr, clint_wdata, clint_wstrb,
      input  clint_rdata, clint_ack
   );

   modport slave (
      input  clint_req, clint_we, clint_addr, clint_wdata, clint_wstrb,
      output clint_rdata, clint_ack
   );

endinterface

// File: rtl/clint_timer_prescaler.sv
// mtime prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle as a tick.
module clint_prescaler #(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   output logic o_tick
);

   logic [15:0] r_tick_cnt;
   logic        w_wrap;

   assign w_wrap = (r_tick_cnt == 16'(TICK_DIV - 1));
   assign o_tick = w_wrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_cnt <= '0;
      end else if (w_wrap) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime/mtimecmp, msip bit, registered mtip,
// all behind a single-cycle request/ack slave port.
module clint_timer
   import clint_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic          clk,
   input  logic          rst,
   clint_timer_if.slave  bus,
   output logic          msip,
   output logic          mtip
);

   logic [63:0] r_mtime;
   logic [63:0] r_mtimecmp;
   logic        r_msip;
   logic        r_mtip;
   logic        r_ack;
   logic [31:0] r_rdata;

   logic        w_tick;
   logic        w_wr;
   clint_sel_e  w_sel;
   logic [31:0] w_rd_val;
   logic [31:0] w_merged;
   logic [63:0] w_mtime_next;
   logic [63:0] w_mtimecmp_next;
   logic        w_msip_next;

   clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .o_tick (w_tick)
   );

   assign w_sel = clint_decode(bus.clint_addr);
   assign w_wr  = bus.clint_req & bus.clint_we;

   always_comb begin
      w_rd_val = '0;
      case (w_sel)
         SEL_MSIP:     w_rd_val = {31'd0, r_msip};
         SEL_CMP_LO:   w_rd_val = r_mtimecmp[31:0];
         SEL_CMP_HI:   w_rd_val = r_mtimecmp[63:32];
         SEL_MTIME_LO: w_rd_val = r_mtime[31:0];
         SEL_MTIME_HI: w_rd_val = r_mtime[63:32];
         default:      w_rd_val = '0;
      endcase
   end

   // Merging against the read mux gives the read-modify-write value for whichever word is hit.
   assign w_merged = clint_merge(w_rd_val, bus.clint_wdata, bus.clint_wstrb);

   always_comb begin
      w_mtime_next    = w_tick ? (r_mtime + 64'd1) : r_mtime;
      w_mtimecmp_next = r_mtimecmp;
      w_msip_next     = r_msip;
      if (w_wr) begin
         case (w_sel)
            SEL_MSIP:     w_msip_next = w_merged[0];
            SEL_CMP_LO:   w_mtimecmp_next = {r_mtimecmp[63:32], w_merged};
            SEL_CMP_HI:   w_mtimecmp_next = {w_merged, r_mtimecmp[31:0]};
            // An mtime write discards that cycle's increment in both halves.
            SEL_MTIME_LO: w_mtime_next = {r_mtime[63:32], w_merged};
            SEL_MTIME_HI: w_mtime_next = {w_merged, r_mtime[31:0]};
            default:      ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mtime    <= '0;
         r_mtimecmp <= CLINT_MTIMECMP_RST;
         r_msip     <= 1'b0;
         r_mtip     <= 1'b0;
         r_ack      <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_mtime    <= w_mtime_next;
         r_mtimecmp <= w_mtimecmp_next;
         r_msip     <= w_msip_next;
         r_mtip     <= (w_mtime_next >= w_mtimecmp_next);
         r_ack      <= bus.clint_req;
         r_rdata    <= (bus.clint_req && !bus.clint_we) ? w_rd_val : '0;
      end
   end

   assign bus.clint_ack   = r_ack;
   assign bus.clint_rdata = r_rdata;
   assign msip            = r_msip;
   assign mtip            = r_mtip;

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: reference model plus read scoreboard on
// a TICK_DIV=1 instance, and a direct prescaler check on a TICK_DIV=4 instance.
module tb_clint_timer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic rst4;
   logic msip, mtip, msip4, mtip4;

   clint_timer_if bif ();
   clint_timer_if bif4 ();

   clint_timer #(.TICK_DIV(1)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bif.slave),
      .msip (msip),
      .mtip (mtip)
   );

   clint_timer #(.TICK_DIV(4)) u_dut4 (
      .clk  (clk),
      .rst  (rst4),
      .bus  (bif4.slave),
      .msip (msip4),
      .mtip (mtip4)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference model of the TICK_DIV=1 instance
   logic [63:0] m_mtime, m_cmp;
   logic        m_msip, m_mtip, exp_ack;
   logic        mon_en;

   typedef struct {
      logic        is_read;
      logic [31:0] data;
   } sb_entry_t;
   sb_entry_t sb_q[$];

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_read(input logic [15:0] a);
      case (a & 16'hFFFC)
         16'h0000: return {31'd0, m_msip};
         16'h4000: return m_cmp[31:0];
         16'h4004: return m_cmp[63:32];
         16'hBFF8: return m_mtime[31:0];
         16'hBFFC: return m_mtime[63:32];
         default:  return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_mtime = 64'd0;
      m_cmp   = {64{1'b1}};
      m_msip  = 1'b0;
      m_mtip  = 1'b0;
      exp_ack = 1'b0;
   endtask

   task automatic bus_cycle(input logic r, input logic req, input logic we,
                            input logic [15:0] a, input logic [31:0] wd, input logic [3:0] ws);
      logic [63:0] t;
      sb_entry_t   e;
      @(negedge clk);
      rst              = r;
      bif.clint_req    = req;
      bif.clint_we     = we;
      bif.clint_addr   = a;
      bif.clint_wdata  = wd;
      bif.clint_wstrb  = ws;
      if (req && !r) begin
         e.is_read = !we;
         e.data    = model_read(a);
         sb_q.push_back(e);
      end
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         t = m_mtime + 64'd1;
         if (req && we) begin
            case (a & 16'hFFFC)
               16'h0000: if (ws[0]) m_msip = wd[0];
               16'h4000: m_cmp[31:0]  = bmerge(m_cmp[31:0], wd, ws);
               16'h4004: m_cmp[63:32] = bmerge(m_cmp[63:32], wd, ws);
               16'hBFF8: t = {m_mtime[63:32], bmerge(m_mtime[31:0], wd, ws)};
               16'hBFFC: t = {bmerge(m_mtime[63:32], wd, ws), m_mtime[31:0]};
               default:  ;
            endcase
         end
         m_mtime = t;
         m_mtip  = (m_mtime >= m_cmp);
         exp_ack = req;
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
      bus_cycle(1'b0, 1'b1, 1'b1, a, d, s);
   endtask

   task automatic rd(input logic [15:0] a);
      bus_cycle(1'b0, 1'b1, 1'b0, a, 32'd0, 4'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 4'd0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         sb_entry_t e;
         chk("ack", bif.clint_ack, exp_ack);
         if (bif.clint_ack) begin
            if (sb_q.size() == 0) begin
               chk("ack_orphan", 1'b1, 1'b0);
            end else begin
               e = sb_q.pop_front();
               if (e.is_read) chk("rdata", bif.clint_rdata, e.data);
            end
         end else begin
            chk("rdata_idle", bif.clint_rdata, 32'd0);
         end
         chk("mtip", mtip, m_mtip);
         chk("msip", msip, m_msip);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      mon_en = 1'b0;
      rst    = 1'b1;
      rst4   = 1'b1;
      model_reset();
      bif.clint_req  = 1'b0; bif.clint_we  = 1'b0; bif.clint_addr  = '0;
      bif.clint_wdata = '0;  bif.clint_wstrb = '0;
      bif4.clint_req = 1'b0; bif4.clint_we = 1'b0; bif4.clint_addr = '0;
      bif4.clint_wdata = '0; bif4.clint_wstrb = '0;

      // TICK_DIV=4: 40 post-reset cycles give mtime = 10
      repeat (2) @(negedge clk);
      rst4 = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      bif4.clint_req  = 1'b1;
      bif4.clint_addr = 16'hBFF8;
      @(posedge clk);
      #1;
      bif4.clint_req = 1'b0;
      chk("d4_ack", bif4.clint_ack, 1'b1);
      chk("d4_mtime_lo", bif4.clint_rdata, 32'd10);
      chk("d4_mtip", mtip4, 1'b0);
      chk("d4_msip", msip4, 1'b0);
      @(posedge clk);
      #1;
      chk("d4_ack_drop", bif4.clint_ack, 1'b0);
      chk("d4_rdata_idle", bif4.clint_rdata, 32'd0);

      // TICK_DIV=1 instance has been in reset throughout
      chk("rst_ack", bif.clint_ack, 1'b0);
      chk("rst_rdata", bif.clint_rdata, 32'd0);
      chk("rst_msip", msip, 1'b0);
      chk("rst_mtip", mtip, 1'b0);
      mon_en = 1'b1;

      // Count since reset, then read back mtime
      idle(10);
      rd(16'hBFF8);
      rd(16'hBFFC);
      rd(16'h4000);
      rd(16'h4004);

      // Timer interrupt around mtime == 20
      wr(16'h4004, 32'd0, 4'hF);
      wr(16'h4000, 32'd20, 4'hF);
      idle(12);
      wr(16'h4000, 32'hFFFF_FFFF, 4'hF);
      wr(16'h4004, 32'hFFFF_FFFF, 4'hF);

      // Software interrupt
      wr(16'h0000, 32'hFFFF_FFFF, 4'hF);
      rd(16'h0000);
      wr(16'h0000, 32'd0, 4'hF);
      rd(16'h0000);

      // Carry from lo into hi, then a write colliding with a tick
      wr(16'hBFFC, 32'd0, 4'hF);
      wr(16'hBFF8, 32'hFFFF_FFFE, 4'hF);
      idle(2);
      rd(16'hBFFC);
      rd(16'hBFF8);
      wr(16'hBFF8, 32'h10, 4'hF);
      rd(16'hBFF8);
      rd(16'hBFFC);

      // Byte strobes and an unmapped offset
      wr(16'h4000, 32'hAABB_CCDD, 4'b0010);
      rd(16'h4000);
      rd(16'h1234);
      wr(16'h1234, 32'h1234_5678, 4'hF);
      rd(16'h4000);
      rd(16'h4004);
      rd(16'h0000);
      wr(16'h4002, 32'h0000_00EE, 4'b0001);
      rd(16'h4000);

      // Full 64-bit wrap of mtime
      wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
      wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
      rd(16'hBFF8);
      rd(16'hBFFC);

      // Reset asserted together with an mtimecmp write
      wr(16'h4000, 32'd5, 4'hF);
      bus_cycle(1'b1, 1'b1, 1'b1, 16'h4000, 32'd0, 4'hF);
      idle(1);
      rd(16'h4000);
      rd(16'h4004);
      rd(16'hBFF8);
      idle(2);

      chk("sb_drain", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/clint_timer.md
# clint_timer

Core-local interruptor for the RV32 core: a 64-bit free-running `mtime` counter, a 64-bit `mtimecmp` compare register and a software-interrupt bit, all memory-mapped on a simple request/acknowledge slave port. It drives the `msip` and `mtip` inputs of the CSR handler, which folds them into `mip` and trap entry. It sits on the data-memory bus decoder next to the UART, which supplies `meip`.

## Interface

Parameters:
- `TICK_DIV`, default 1: core clocks per `mtime` increment. Legal range is 1..65535; 1 means increment every cycle.

Ports:
- `clk`  in  1  core clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `clint_req`  in  1  bus request, valid for one cycle per access.
- `clint_we`  in  1  1 = write, 0 = read.
- `clint_addr`  in  16  byte offset within the CLINT window; `[1:0]` is ignored.
- `clint_wdata`  in  32  write data.
- `clint_wstrb`  in  4  byte enables for writes.
- `clint_rdata`  out  32  read data, valid while `clint_ack` = 1.
- `clint_ack`  out  1  access complete; one cycle after `clint_req`.
- `msip`  out  1  machine software interrupt pending.
- `mtip`  out  1  machine timer interrupt pending.

## Operation

Register map (word offsets):
- `0x0000`: `msip`. Only bit 0 is implemented; bits 31:1 read 0.
- `0x4000` / `0x4004`: `mtimecmp[31:0]` / `mtimecmp[63:32]`.
- `0xBFF8` / `0xBFFC`: `mtime[31:0]` / `mtime[63:32]`.
- Any other offset: reads return 0, writes are dropped, and the access is still acked.

Writes:
- Each byte lane is updated only if its `clint_wstrb` bit is set.
- A write to one half of `mtime` or `mtimecmp` leaves the other half unchanged, and never propagates a carry into it.

Prescaler:
- `tick_cnt` counts from 0 to `TICK_DIV-1`, then wraps to 0.
- `tick` is asserted on the wrap cycle.
- On `tick`, `mtime <= mtime + 1`, as a full 64-bit add. The wrap from `0xFFFF_FFFF_FFFF_FFFF` to 0 is silent.

Simultaneous events:
- A bus write to an `mtime` half in the same cycle as `tick`: the written bytes take the write data, and the increment is discarded for that whole cycle.
- A write never resets `tick_cnt`.

Interrupt outputs:
- `mtip` is registered: `mtip <= (mtime_next >= mtimecmp_next)`, an unsigned 64-bit compare of the values being committed this cycle.
- `msip` is the stored bit 0 of the `msip` register.
- Both outputs are level signals. They stay asserted until software clears the source, by rewriting `mtimecmp` or `msip`.

Reads:
- Reads are live: no hi/lo snapshot. Software uses the hi/lo/hi retry loop.
- A read returns the register value as it stood at the `clint_req` edge.

## Timing

Reset values:
- `mtime` = 0.
- `mtimecmp` = `0xFFFF_FFFF_FFFF_FFFF`.
- `msip` = 0, `mtip` = 0.
- `clint_ack` = 0, `clint_rdata` = 0, `tick_cnt` = 0.

Bus timing:
- Request in cycle N gives `clint_ack` = 1 with `clint_rdata` in cycle N+1. Writes take effect at the end of cycle N.
- Back-to-back requests are allowed: one per cycle, each acked in the following cycle.
- `clint_rdata` is 0 whenever `clint_ack` = 0.

Interrupt timing:
- `mtip` reflects a `mtimecmp` or `mtime` write in cycle N+1.
- `msip` reflects a write in cycle N+1.

Reset during operation:
- `rst` asserted during an access: the pending ack is dropped and the next cycle shows reset values.

## Structure

- The shared package (`csr_defs.v` style include) defines:
  - the offsets `CLINT_MSIP_OFF`, `CLINT_MTIMECMP_LO_OFF`, `CLINT_MTIMECMP_HI_OFF`, `CLINT_MTIME_LO_OFF`, `CLINT_MTIME_HI_OFF`;
  - the reset constant `CLINT_MTIMECMP_RST`.
- One sub-module is natural: `clint_prescaler`, a `TICK_DIV` counter that outputs `tick`.
- The register file, byte-lane merge, comparator and bus logic stay in the top module.

## Test plan

- Reset and count:
  - Stimulus: `TICK_DIV`=1, release `rst`, wait 10 cycles, then read `0xBFF8`.
  - Required: the value read equals the cycle count since reset, with `clint_ack` asserted exactly one cycle after `clint_req`.
- Timer interrupt:
  - Stimulus: write `mtimecmp` hi = 0, then lo = 20.
  - Required: `mtip` = 0 until `mtime` reaches 20, then 1 one cycle later.
  - Stimulus: write lo = `0xFFFF_FFFF`.
  - Required: `mtip` returns to 0 in the next cycle.
- Software interrupt:
  - Stimulus: write `0x0000` = `0xFFFF_FFFF`.
  - Required: `msip` = 1 next cycle, and a read of `0x0000` returns 1.
  - Stimulus: write 0.
  - Required: `msip` = 0.
- Carry and collision:
  - Stimulus: set `mtime` = `0x0000_0000_FFFF_FFFE` and run 3 ticks.
  - Required: hi reads 1, lo reads 1.
  - Stimulus: write lo = `0x10` on a `tick` cycle.
  - Required: lo reads `0x10`, not `0x11`.
- Strobes and unmapped offsets:
  - Stimulus: write `mtimecmp` lo with `clint_wstrb` = `4'b0010` and data `0xAABBCCDD`.
  - Required: lo reads `0xFFFFCCFF`.
  - Stimulus: read and write `0x1234`.
  - Required: read returns 0, both accesses are acked, and no register changes.
- Prescaler and reset:
  - Stimulus: `TICK_DIV`=4 and 40 cycles.
  - Required: `mtime` = 10.
  - Stimulus: assert `rst` in the same cycle as a write to `mtimecmp`.
  - Required: `mtimecmp` = all ones, `clint_ack` = 0.
